// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for a single shared register.
// Define SHARED_REG_PRIORITY_EN to give requester 0 fixed top priority.
module shared_reg_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wr_data,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       q,
  output logic                   busy
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [IW-1:0]    ptr, ptr_nxt;
  logic [IW-1:0]    gidx, gidx_nxt;
  logic [N_REQ-1:0] gnt_nxt, ack_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             busy_nxt;
  logic [IW-1:0]    win;
  logic [IW-1:0]    ptr_upd;
  logic [N_REQ-1:0] req_sh;
  logic             gnt_req;
  logic [WIDTH-1:0] slice;

  // First asserted request scanning p+1, p+2, ... modulo N_REQ.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [IW-1:0]    p);
    logic [IW-1:0]    pick;
    logic             hit;
    logic [N_REQ-1:0] sh;
    int               idx;
    pick = '0;
    hit  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(p) + k) % N_REQ;
      sh  = r >> idx;
      if (!hit && sh[0]) begin
        pick = IW'(idx);
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
    return {{(N_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  always_comb begin
`ifdef SHARED_REG_PRIORITY_EN
    win     = req[0] ? '0 : rr_pick(req, ptr);
    ptr_upd = (gidx == '0) ? ptr : gidx;
`else
    win     = rr_pick(req, ptr);
    ptr_upd = gidx;
`endif
  end

  assign req_sh  = req >> gidx;
  assign gnt_req = req_sh[0];
  assign slice   = WIDTH'(wr_data >> (int'(gidx) * WIDTH));

  // Next-state and registered-output decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    gidx_nxt  = gidx;
    gnt_nxt   = gnt;
    ack_nxt   = '0;
    q_nxt     = q;
    unique case (state)
      IDLE: begin
        if (|req) begin
          gidx_nxt  = win;
          gnt_nxt   = onehot(win);
          cnt_nxt   = 4'd0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        cnt_nxt = cnt + 4'd1;
        if (!gnt_req) begin
          gnt_nxt   = '0;
          ptr_nxt   = ptr_upd;
          state_nxt = RELEASE;
        end else if (cnt == 4'(HOLD_CYCLES - 1)) begin
          q_nxt     = slice;
          ack_nxt   = gnt;
          gnt_nxt   = '0;
          ptr_nxt   = ptr_upd;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ptr   <= IW'(N_REQ - 1);
      gidx  <= '0;
      gnt   <= '0;
      ack   <= '0;
      q     <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      gidx  <= gidx_nxt;
      gnt   <= gnt_nxt;
      ack   <= ack_nxt;
      q     <= q_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: reset, rotation, single write, abandon, reset mid-grant.
module tb_shared_reg_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wr_data;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  shared_reg_arbiter #(
    .N_REQ(4),
    .WIDTH(8),
    .HOLD_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .wr_data(wr_data),
    .gnt(gnt),
    .ack(ack),
    .q(q),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b0;
    req     = 4'b1111;
    wr_data = {8'h13, 8'h12, 8'h11, 8'h10};

    // Reset held low with all requests asserted
    tick;
    tick;
    tick;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;

    // Rotation with all requests held
    for (int n = 0; n < 5; n++) begin
      int e;
`ifdef SHARED_REG_PRIORITY_EN
      e = 0;
`else
      e = n % 4;
`endif
      tick;
      chk("rot_gnt", 32'(gnt), 1 << e);
      chk("rot_busy", 32'(busy), 32'h1);
      tick;
      chk("rot_hold", 32'(gnt), 1 << e);
      chk("rot_noack", 32'(ack), 32'h0);
      tick;
      chk("rot_ack", 32'(ack), 1 << e);
      chk("rot_gnt_off", 32'(gnt), 32'h0);
      chk("rot_q", 32'(q), 32'h10 + e);
      if (n == 4) req = 4'b0000;
      tick;
      chk("rot_idle_busy", 32'(busy), 32'h0);
      chk("rot_idle_ack", 32'(ack), 32'h0);
      chk("rot_idle_gnt", 32'(gnt), 32'h0);
    end

    // Single write from requester 2
    wr_data[23:16] = 8'hA5;
    req = 4'b0100;
    tick;
    chk("sw_gnt0", 32'(gnt), 32'h4);
    tick;
    chk("sw_gnt1", 32'(gnt), 32'h4);
    chk("sw_noack", 32'(ack), 32'h0);
    tick;
    chk("sw_q", 32'(q), 32'hA5);
    chk("sw_ack", 32'(ack), 32'h4);
    chk("sw_gnt_off", 32'(gnt), 32'h0);
    chk("sw_busy_rel", 32'(busy), 32'h1);
    req = 4'b0000;
    tick;
    chk("sw_ack_pulse", 32'(ack), 32'h0);
    chk("sw_busy_idle", 32'(busy), 32'h0);

    // Preload q with 3C through requester 3
    wr_data[31:24] = 8'h3C;
    req = 4'b1000;
    tick;
    chk("pl_gnt", 32'(gnt), 32'h8);
    tick;
    tick;
    chk("pl_q", 32'(q), 32'h3C);
    chk("pl_ack", 32'(ack), 32'h8);
    req = 4'b0000;
    tick;

    // Abandon: requester 1 drops in its first grant cycle
    wr_data[15:8] = 8'h77;
    req = 4'b0010;
    tick;
    chk("ab_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick;
    chk("ab_gnt_clr", 32'(gnt), 32'h0);
    chk("ab_noack", 32'(ack), 32'h0);
    chk("ab_q_kept", 32'(q), 32'h3C);
    chk("ab_busy_rel", 32'(busy), 32'h1);
    tick;
    chk("ab_noack2", 32'(ack), 32'h0);
    chk("ab_busy_idle", 32'(busy), 32'h0);
    chk("ab_q_kept2", 32'(q), 32'h3C);
    req = 4'b0110;
    tick;
    chk("ab_next_gnt", 32'(gnt), 32'h4);
    tick;
    tick;
    chk("ab_next_q", 32'(q), 32'hA5);
    chk("ab_next_ack", 32'(ack), 32'h4);
    req = 4'b0000;
    tick;

    // Reset asserted mid-grant for requester 3
    req = 4'b1000;
    tick;
    chk("rm_gnt", 32'(gnt), 32'h8);
    #2;
    reset = 1'b0;
    #1;
    chk("rm_gnt_clr", 32'(gnt), 32'h0);
    chk("rm_q_clr", 32'(q), 32'h0);
    chk("rm_busy", 32'(busy), 32'h0);
    tick;
    chk("rm_noack", 32'(ack), 32'h0);
    tick;
    chk("rm_noack2", 32'(ack), 32'h0);
    chk("rm_q_hold", 32'(q), 32'h0);
    reset = 1'b1;
    req   = 4'b1111;
    tick;
    chk("rm_first_gnt", 32'(gnt), 32'h1);
    tick;
    chk("rm_noack3", 32'(ack), 32'h0);
    tick;
    chk("rm_ack0", 32'(ack), 32'h1);
    chk("rm_q0", 32'(q), 32'h10);
    req = 4'b0000;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
